// File: rtl/mult_prod_accum.sv
// Accumulates N_TERMS multiplier products per group and presents the group sum on a
// valid/ready port, holding it (and asserting busy) until the consumer accepts it.
module mult_prod_accum #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned N_TERMS = 4,
    parameter int unsigned ACC_W   = 18
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           clear,
    input  logic [2*WIDTH-1:0]             prod,
    input  logic                           prod_done,
    output logic                           busy,
    output logic [$clog2(N_TERMS+1)-1:0]   term_cnt,
    output logic [ACC_W-1:0]               sum,
    output logic                           sum_ovf,
    output logic                           sum_valid,
    input  logic                           sum_ready,
    output logic                           err
);

    localparam int unsigned CNT_W = $clog2(N_TERMS + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_TERMS - 1);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic [ACC_W-1:0]   sum_q, sum_d;
    logic               sum_ovf_q, sum_ovf_d;
    logic               sum_valid_q, sum_valid_d;
    logic               busy_q;
    logic               err_q, err_d;
    logic [ACC_W:0]     add_ext;

    // One extra bit on the adder exposes the carry-out used for the wrap flag.
    assign add_ext = {1'b0, acc_q} + (ACC_W + 1)'(prod);

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            state_q     <= ACCUM;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            sum_q       <= '0;
            sum_ovf_q   <= 1'b0;
            sum_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            sum_q       <= sum_d;
            sum_ovf_q   <= sum_ovf_d;
            sum_valid_q <= sum_valid_d;
            busy_q      <= (state_d == HOLD);
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        sum_d       = sum_q;
        sum_ovf_d   = sum_ovf_q;
        sum_valid_d = sum_valid_q;
        err_d       = err_q;

        unique case (state_q)
            ACCUM: begin
                if (prod_done) begin
                    if (cnt_q == LAST_CNT) begin
                        sum_d       = add_ext[ACC_W-1:0];
                        sum_ovf_d   = ovf_q | add_ext[ACC_W];
                        sum_valid_d = 1'b1;
                        acc_d       = '0;
                        cnt_d       = '0;
                        ovf_d       = 1'b0;
                        state_d     = HOLD;
                    end else begin
                        acc_d = add_ext[ACC_W-1:0];
                        cnt_d = cnt_q + CNT_W'(1);
                        ovf_d = ovf_q | add_ext[ACC_W];
                    end
                end
            end
            HOLD: begin
                if (sum_valid_q && sum_ready) begin
                    if (prod_done && (N_TERMS == 1)) begin
                        // Single-term groups: the new product is itself the next result.
                        sum_d       = ACC_W'(prod);
                        sum_ovf_d   = 1'b0;
                        sum_valid_d = 1'b1;
                    end else if (prod_done) begin
                        sum_valid_d = 1'b0;
                        acc_d       = ACC_W'(prod);
                        cnt_d       = CNT_W'(1);
                        ovf_d       = 1'b0;
                        state_d     = ACCUM;
                    end else begin
                        sum_valid_d = 1'b0;
                        state_d     = ACCUM;
                    end
                end else if (prod_done) begin
                    err_d = 1'b1;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    assign busy      = busy_q;
    assign term_cnt  = cnt_q;
    assign sum       = sum_q;
    assign sum_ovf   = sum_ovf_q;
    assign sum_valid = sum_valid_q;
    assign err       = err_q;

endmodule
